// File: rtl/cp0_regfile_p.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cp0_regfile_p                                                |
// | Brief   : Parametrised MIPS CP0 register file with TLB, timer and      |
// |           interrupt support, committed beside the WB stage.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module cp0_regfile_p #(
    parameter int          TLB_NUM     = 16,
    parameter int          COUNT_DIV   = 2,
    parameter logic [31:0] COMPARE_RST = 32'h0000_FFFF,
    localparam int         IDX_W       = $clog2(TLB_NUM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wb_valid,
    input  logic             wb_ex,
    input  logic [4:0]       wb_excode,
    input  logic             wb_refill,
    input  logic             wb_bd,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_badvaddr,
    input  logic             wb_mtc0,
    input  logic             wb_eret,
    input  logic             wb_tlbp,
    input  logic             wb_tlbr,
    input  logic             wb_tlbwr,
    input  logic [7:0]       wb_addr,
    input  logic [31:0]      wb_wdata,
    input  logic [5:0]       ext_int,
    input  logic             tlbp_found,
    input  logic [IDX_W-1:0] tlbp_index,
    input  logic [31:0]      tlb_r_hi,
    input  logic [31:0]      tlb_r_lo0,
    input  logic [31:0]      tlb_r_lo1,
    output logic [31:0]      rdata,
    output logic [31:0]      cp0_entryhi,
    output logic [31:0]      cp0_entrylo0,
    output logic [31:0]      cp0_entrylo1,
    output logic [IDX_W-1:0] cp0_index,
    output logic [IDX_W-1:0] cp0_random,
    output logic             eret_flush,
    output logic [31:0]      ex_entry,
    output logic [31:0]      epc,
    output logic             int_req
);

    localparam logic [7:0] c_addr_index    = 8'd0;
    localparam logic [7:0] c_addr_random   = 8'd8;
    localparam logic [7:0] c_addr_entrylo0 = 8'd16;
    localparam logic [7:0] c_addr_entrylo1 = 8'd24;
    localparam logic [7:0] c_addr_context  = 8'd32;
    localparam logic [7:0] c_addr_wired    = 8'd48;
    localparam logic [7:0] c_addr_badvaddr = 8'd64;
    localparam logic [7:0] c_addr_count    = 8'd72;
    localparam logic [7:0] c_addr_entryhi  = 8'd80;
    localparam logic [7:0] c_addr_compare  = 8'd88;
    localparam logic [7:0] c_addr_status   = 8'd96;
    localparam logic [7:0] c_addr_cause    = 8'd104;
    localparam logic [7:0] c_addr_epc      = 8'd112;

    localparam int               c_ps_w     = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [c_ps_w-1:0] c_ps_max  = c_ps_w'(COUNT_DIV - 1);
    localparam logic [IDX_W-1:0] c_rand_max = {IDX_W{1'b1}};

    logic [7:0]        r_im;
    logic              r_exl, r_ie;
    logic              r_bd, r_ti;
    logic [7:0]        r_ip;
    logic [4:0]        r_exc;
    logic [31:0]       r_epc, r_badvaddr, r_count, r_compare;
    logic [c_ps_w-1:0] r_prescale;
    logic [8:0]        r_ptebase;
    logic [18:0]       r_badvpn2, r_vpn2;
    logic [7:0]        r_asid;
    logic [25:0]       r_lo0, r_lo1;
    logic              r_index_p;
    logic [IDX_W-1:0]  r_index, r_wired, r_random;
    logic              r_int_req;

    logic w_ex, w_commit, w_mtc0, w_eret, w_tlbp, w_tlbr, w_tlb_ex, w_addr_ex;
    logic w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_context, w_wr_wired, w_wr_count;
    logic w_wr_entryhi, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;

    assign w_ex      = wb_valid & wb_ex;
    assign w_commit  = wb_valid & ~wb_ex;
    assign w_mtc0    = w_commit & wb_mtc0;
    assign w_eret    = w_commit & wb_eret;
    assign w_tlbp    = w_commit & wb_tlbp;
    assign w_tlbr    = w_commit & wb_tlbr;
    assign w_tlb_ex  = w_ex & (wb_excode >= 5'd1) & (wb_excode <= 5'd3);
    assign w_addr_ex = w_ex & (wb_excode >= 5'd1) & (wb_excode <= 5'd5);

    assign w_wr_index   = w_mtc0 & (wb_addr == c_addr_index);
    assign w_wr_lo0     = w_mtc0 & (wb_addr == c_addr_entrylo0);
    assign w_wr_lo1     = w_mtc0 & (wb_addr == c_addr_entrylo1);
    assign w_wr_context = w_mtc0 & (wb_addr == c_addr_context);
    assign w_wr_wired   = w_mtc0 & (wb_addr == c_addr_wired);
    assign w_wr_count   = w_mtc0 & (wb_addr == c_addr_count);
    assign w_wr_entryhi = w_mtc0 & (wb_addr == c_addr_entryhi);
    assign w_wr_compare = w_mtc0 & (wb_addr == c_addr_compare);
    assign w_wr_status  = w_mtc0 & (wb_addr == c_addr_status);
    assign w_wr_cause   = w_mtc0 & (wb_addr == c_addr_cause);
    assign w_wr_epc     = w_mtc0 & (wb_addr == c_addr_epc);

    // TLBWR needs only cp0_random and the EntryHi/Lo images; CP0 state is untouched.
    logic w_unused;
    assign w_unused = &{1'b0, wb_tlbwr, tlb_r_hi[12:8], tlb_r_lo0[31:26], tlb_r_lo1[31:26]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im <= '0; r_exl <= 1'b0; r_ie <= 1'b0;
            r_bd <= 1'b0; r_ti <= 1'b0; r_ip <= '0; r_exc <= '0;
            r_epc <= '0; r_badvaddr <= '0;
            r_count <= '0; r_prescale <= '0; r_compare <= COMPARE_RST;
            r_ptebase <= '0; r_badvpn2 <= '0; r_vpn2 <= '0; r_asid <= '0;
            r_lo0 <= '0; r_lo1 <= '0;
            r_index_p <= 1'b0; r_index <= '0; r_wired <= '0; r_random <= c_rand_max;
            r_int_req <= 1'b0;
        end else begin
            if (w_ex)             r_exl <= 1'b1;
            else if (w_eret)      r_exl <= 1'b0;
            else if (w_wr_status) r_exl <= wb_wdata[1];
            if (w_wr_status) begin
                r_im <= wb_wdata[15:8];
                r_ie <= wb_wdata[0];
            end

            r_ip[7:2] <= {ext_int[5] | r_ti, ext_int[4:0]};
            if (w_wr_cause) r_ip[1:0] <= wb_wdata[9:8];
            // Acknowledge via Compare write takes precedence over a fresh match.
            if (w_wr_compare)              r_ti <= 1'b0;
            else if (r_count == r_compare) r_ti <= 1'b1;
            if (w_ex) begin
                r_exc <= wb_excode;
                if (!r_exl) r_bd <= wb_bd;
            end

            if (w_ex && !r_exl) r_epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
            else if (w_wr_epc)  r_epc <= wb_wdata;
            if (w_addr_ex) r_badvaddr <= wb_badvaddr;

            if (w_wr_count) begin
                r_count    <= wb_wdata;
                r_prescale <= '0;
            end else if (r_prescale == c_ps_max) begin
                r_count    <= r_count + 32'd1;
                r_prescale <= '0;
            end else begin
                r_prescale <= r_prescale + 1'b1;
            end
            if (w_wr_compare) r_compare <= wb_wdata;

            if (w_wr_context) r_ptebase <= wb_wdata[31:23];
            if (w_tlb_ex)     r_badvpn2 <= wb_badvaddr[31:13];

            if (w_tlb_ex) begin
                r_vpn2 <= wb_badvaddr[31:13];
            end else if (w_wr_entryhi) begin
                r_vpn2 <= wb_wdata[31:13];
                r_asid <= wb_wdata[7:0];
            end else if (w_tlbr) begin
                r_vpn2 <= tlb_r_hi[31:13];
                r_asid <= tlb_r_hi[7:0];
            end

            if (w_wr_lo0)    r_lo0 <= wb_wdata[25:0];
            else if (w_tlbr) r_lo0 <= tlb_r_lo0[25:0];
            if (w_wr_lo1)    r_lo1 <= wb_wdata[25:0];
            else if (w_tlbr) r_lo1 <= tlb_r_lo1[25:0];

            if (w_tlbp) begin
                r_index_p <= ~tlbp_found;
                if (tlbp_found) r_index <= tlbp_index;
            end else if (w_wr_index) begin
                r_index <= wb_wdata[IDX_W-1:0];
            end

            if (w_wr_wired) r_wired <= wb_wdata[IDX_W-1:0];
            if (w_wr_wired || (r_wired >= c_rand_max) || (r_random == r_wired))
                r_random <= c_rand_max;
            else
                r_random <= r_random - 1'b1;

            r_int_req <= (|(r_ip & r_im)) & r_ie & ~r_exl;
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (wb_addr)
            c_addr_index:    rdata = {r_index_p, {(31-IDX_W){1'b0}}, r_index};
            c_addr_random:   rdata = {{(32-IDX_W){1'b0}}, r_random};
            c_addr_entrylo0: rdata = {6'b0, r_lo0};
            c_addr_entrylo1: rdata = {6'b0, r_lo1};
            c_addr_context:  rdata = {r_ptebase, r_badvpn2, 4'b0};
            c_addr_wired:    rdata = {{(32-IDX_W){1'b0}}, r_wired};
            c_addr_badvaddr: rdata = r_badvaddr;
            c_addr_count:    rdata = r_count;
            c_addr_entryhi:  rdata = {r_vpn2, 5'b0, r_asid};
            c_addr_compare:  rdata = r_compare;
            c_addr_status:   rdata = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
            c_addr_cause:    rdata = {r_bd, r_ti, 14'b0, r_ip, 1'b0, r_exc, 2'b0};
            c_addr_epc:      rdata = r_epc;
            default:         rdata = 32'h0;
        endcase
    end

    assign cp0_entryhi  = {r_vpn2, 5'b0, r_asid};
    assign cp0_entrylo0 = {6'b0, r_lo0};
    assign cp0_entrylo1 = {6'b0, r_lo1};
    assign cp0_index    = r_index;
    assign cp0_random   = r_random;
    assign eret_flush   = wb_valid & wb_eret & ~wb_ex;
    assign ex_entry     = (wb_refill & ~r_exl & ((wb_excode == 5'd2) | (wb_excode == 5'd3)))
                          ? 32'hBFC0_0200 : 32'hBFC0_0380;
    assign epc          = r_epc;
    assign int_req      = r_int_req;

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile_p.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_cp0_regfile_p                                             |
// | Brief   : Directed scoreboard bench for cp0_regfile_p (TLB_NUM=16).    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_cp0_regfile_p;

    localparam int K_RDATA = 0, K_EXENTRY = 1, K_ERET = 2, K_INTREQ = 3;
    localparam int K_INDEX = 4, K_RANDOM = 5, K_ENTRYHI = 6;

    localparam logic [7:0] A_INDEX = 8'd0,  A_RANDOM = 8'd8,  A_LO0 = 8'd16, A_LO1 = 8'd24;
    localparam logic [7:0] A_CTX = 8'd32,   A_WIRED = 8'd48,  A_BVA = 8'd64, A_COUNT = 8'd72;
    localparam logic [7:0] A_HI = 8'd80,    A_CMP = 8'd88,    A_STATUS = 8'd96;
    localparam logic [7:0] A_CAUSE = 8'd104, A_EPC = 8'd112;

    logic        clk, resetn;
    logic        wb_valid, wb_ex, wb_refill, wb_bd;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc, wb_badvaddr, wb_wdata;
    logic        wb_mtc0, wb_eret, wb_tlbp, wb_tlbr, wb_tlbwr;
    logic [7:0]  wb_addr;
    logic [5:0]  ext_int;
    logic        tlbp_found;
    logic [3:0]  tlbp_index;
    logic [31:0] tlb_r_hi, tlb_r_lo0, tlb_r_lo1;
    logic [31:0] rdata, cp0_entryhi, cp0_entrylo0, cp0_entrylo1, ex_entry, epc;
    logic [3:0]  cp0_index, cp0_random;
    logic        eret_flush, int_req;

    cp0_regfile_p #(.TLB_NUM(16), .COUNT_DIV(2), .COMPARE_RST(32'h0000_FFFF)) dut (
        .clk(clk), .resetn(resetn),
        .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_refill(wb_refill),
        .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
        .wb_mtc0(wb_mtc0), .wb_eret(wb_eret), .wb_tlbp(wb_tlbp), .wb_tlbr(wb_tlbr),
        .wb_tlbwr(wb_tlbwr), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .ext_int(ext_int),
        .tlbp_found(tlbp_found), .tlbp_index(tlbp_index),
        .tlb_r_hi(tlb_r_hi), .tlb_r_lo0(tlb_r_lo0), .tlb_r_lo1(tlb_r_lo1),
        .rdata(rdata), .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
        .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index), .cp0_random(cp0_random),
        .eret_flush(eret_flush), .ex_entry(ex_entry), .epc(epc), .int_req(int_req)
    );

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
    always @(negedge clk) begin
        chk_t        e;
        logic [31:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_RDATA:   act = rdata;
                K_EXENTRY: act = ex_entry;
                K_ERET:    act = {31'b0, eret_flush};
                K_INTREQ:  act = {31'b0, int_req};
                K_INDEX:   act = {28'b0, cp0_index};
                K_RANDOM:  act = {28'b0, cp0_random};
                K_ENTRYHI: act = cp0_entryhi;
                default:   act = 32'hDEAD_BEEF;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input string n, input int k, input logic [31:0] v);
        chk_t e;
        e.name = n; e.kind = k; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_ex = 1'b0; wb_refill = 1'b0; wb_bd = 1'b0;
        wb_mtc0 = 1'b0; wb_eret = 1'b0; wb_tlbp = 1'b0; wb_tlbr = 1'b0; wb_tlbwr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input string n, input logic [31:0] v);
        idle();
        wb_addr = a;
        push(n, K_RDATA, v);
        tick();
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        idle();
        wb_valid = 1'b1; wb_mtc0 = 1'b1; wb_addr = a; wb_wdata = d;
        tick();
        idle();
    endtask

    task automatic take_ex(input logic [4:0] code, input logic refill, input logic bd,
                           input logic [31:0] pc, input logic [31:0] bva,
                           input logic [31:0] exp_entry, input string n);
        idle();
        wb_valid = 1'b1; wb_ex = 1'b1; wb_excode = code; wb_refill = refill;
        wb_bd = bd; wb_pc = pc; wb_badvaddr = bva;
        push(n, K_EXENTRY, exp_entry);
        push({n, "_flush"}, K_ERET, 32'h0);
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle();
        wb_excode = '0; wb_pc = '0; wb_badvaddr = '0; wb_addr = '0; wb_wdata = '0;
        ext_int = '0; tlbp_found = 1'b0; tlbp_index = '0;
        tlb_r_hi = '0; tlb_r_lo0 = '0; tlb_r_lo1 = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        push("rst_random_port", K_RANDOM, 32'd15);
        push("rst_int_req", K_INTREQ, 32'd0);
        push("rst_eret_flush", K_ERET, 32'd0);
        rd(A_RANDOM, "rst_random", 32'd15);
        rd(A_STATUS, "rst_status", 32'h0040_0000);
        rd(A_CMP, "rst_compare", 32'h0000_FFFF);
        rd(A_CAUSE, "rst_cause", 32'h0);

        // Wired / Random
        mtc0(A_WIRED, 32'd4);
        for (int v = 15; v >= 4; v--) rd(A_RANDOM, "random_dec", 32'(v));
        rd(A_RANDOM, "random_wrap", 32'd15);
        rd(A_WIRED, "wired", 32'd4);
        mtc0(A_WIRED, 32'd15);
        for (int i = 0; i < 3; i++) rd(A_RANDOM, "random_hold", 32'd15);
        mtc0(A_WIRED, 32'd0);

        // Timer: Count every 2 cycles, TI -> IP7 -> int_req
        mtc0(A_STATUS, 32'h0000_8001);
        mtc0(A_COUNT, 32'd0);
        mtc0(A_CMP, 32'd10);
        repeat (18) tick();
        rd(A_COUNT, "count_9", 32'd9);
        rd(A_CAUSE, "ti_not_yet", 32'h0);
        push("timer_irq_0a", K_INTREQ, 32'd0);
        rd(A_CAUSE, "ti_set", 32'h4000_0000);
        push("timer_irq_0b", K_INTREQ, 32'd0);
        rd(A_CAUSE, "ip7_set", 32'h4000_8000);
        push("timer_irq_1", K_INTREQ, 32'd1);
        rd(A_COUNT, "count_11", 32'd11);
        mtc0(A_CMP, 32'hFFFF_0000);
        rd(A_CAUSE, "ti_clear", 32'h0000_8000);
        rd(A_CAUSE, "ip7_clear", 32'h0);
        push("timer_irq_off", K_INTREQ, 32'd0);
        mtc0(A_STATUS, 32'h0);

        // TLBS refill in a delay slot, then a nested TLBL
        take_ex(5'd3, 1'b1, 1'b1, 32'h8000_0104, 32'h1234_5678, 32'hBFC0_0200, "refill_vec");
        rd(A_EPC, "epc_bd", 32'h8000_0100);
        rd(A_CAUSE, "cause_tlbs", 32'h8000_000C);
        push("entryhi_port", K_ENTRYHI, 32'h1234_4000);
        rd(A_HI, "entryhi_vpn2", 32'h1234_4000);
        rd(A_CTX, "context_vpn2", 32'h0009_1A20);
        rd(A_STATUS, "status_exl", 32'h0040_0002);
        rd(A_BVA, "badvaddr1", 32'h1234_5678);
        take_ex(5'd2, 1'b1, 1'b0, 32'h8000_0200, 32'h0040_2000, 32'hBFC0_0380, "nested_vec");
        rd(A_EPC, "epc_kept", 32'h8000_0100);
        rd(A_CAUSE, "cause_nested", 32'h8000_0008);
        rd(A_BVA, "badvaddr2", 32'h0040_2000);
        rd(A_HI, "entryhi2", 32'h0040_2000);
        mtc0(A_CTX, 32'hFFFF_FFFF);
        rd(A_CTX, "context_ptebase", 32'hFF80_2010);

        // TLBP / TLBR / Index
        idle(); wb_valid = 1'b1; wb_tlbp = 1'b1; tlbp_found = 1'b0; tlbp_index = 4'd5;
        tick(); idle();
        push("index_port_miss", K_INDEX, 32'd0);
        rd(A_INDEX, "tlbp_miss", 32'h8000_0000);
        idle(); wb_valid = 1'b1; wb_tlbp = 1'b1; tlbp_found = 1'b1; tlbp_index = 4'd7;
        tick(); idle();
        rd(A_INDEX, "tlbp_hit", 32'h0000_0007);
        idle(); wb_valid = 1'b1; wb_tlbr = 1'b1;
        tlb_r_hi = 32'hABCD_E0FF; tlb_r_lo0 = 32'h0000_1F47; tlb_r_lo1 = 32'hFC00_0005;
        tick(); idle();
        rd(A_LO0, "tlbr_lo0", 32'h0000_1F47);
        rd(A_LO1, "tlbr_lo1", 32'h0000_0005);
        rd(A_HI, "tlbr_hi", 32'hABCD_E0FF);
        mtc0(A_INDEX, 32'hFFFF_FFFF);
        rd(A_INDEX, "mtc0_index", 32'h0000_000F);

        // ERET clears EXL, then external interrupt on IP4
        idle(); wb_valid = 1'b1; wb_eret = 1'b1;
        push("eret_flush", K_ERET, 32'd1);
        tick(); idle();
        mtc0(A_STATUS, 32'h0000_1001);
        ext_int = 6'b000100;
        push("ext_irq_0a", K_INTREQ, 32'd0);
        rd(A_STATUS, "status_im4", 32'h0040_1001);
        ext_int = 6'b000000;
        push("ext_irq_0b", K_INTREQ, 32'd0);
        rd(A_CAUSE, "cause_ip4", 32'h8000_1008);
        push("ext_irq_1", K_INTREQ, 32'd1);
        rd(A_CAUSE, "cause_ip4_gone", 32'h8000_0008);
        push("ext_irq_off", K_INTREQ, 32'd0);

        // ERET together with an exception: exception wins
        idle(); wb_valid = 1'b1; wb_eret = 1'b1; wb_ex = 1'b1; wb_excode = 5'd0;
        wb_bd = 1'b0; wb_pc = 32'h8000_0300;
        push("eret_ex_flush", K_ERET, 32'd0);
        push("int_vec", K_EXENTRY, 32'hBFC0_0380);
        tick(); idle();
        rd(A_STATUS, "eret_ex_exl", 32'h0040_1003);
        rd(A_EPC, "epc_int", 32'h8000_0300);
        rd(A_CAUSE, "cause_int", 32'h0);
        rd(8'd1, "unmapped", 32'h0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
